amdc_gpio_io_conditioner: RTL
=============================

AMDC_GPIO_IO_CONDITIONER -- requirements
Module: amdc_gpio_io_conditioner

Interface
REQ-001 Parameter N_CH, default 4, number of GPIO channels, one output and one input pin per channel.
REQ-002 Parameter DB_W, default 16, debounce counter and limit width in bits.
REQ-003 ACLK  input  1  sole clock; every register updates on its rising edge.
REQ-004 ARESET  input  1  synchronous active-high reset, sampled on the ACLK rising edge.
REQ-005 out_data_reg  input  N_CH  output pin values from the AXI4-Lite register file.
REQ-006 gpio_out  output  N_CH  registered pin drive.
REQ-007 gpio_in  input  N_CH  raw asynchronous pin inputs.
REQ-008 db_limit  input  DB_W  debounce threshold in cycles, register-file driven.
REQ-009 in_state  output  N_CH  debounced input level, readable by the register file.
REQ-010 rise_flags  output  N_CH  sticky rising-edge flags.
REQ-011 fall_flags  output  N_CH  sticky falling-edge flags.
REQ-012 flag_clr  input  N_CH  one-cycle write-1-to-clear pulse per channel, clears both the rise and fall flag.
REQ-013 irq_mask  input  N_CH  per-channel interrupt enable.
REQ-014 irq  output  1  registered interrupt request.

Function
REQ-015 gpio_out SHALL equal out_data_reg delayed by exactly one ACLK cycle.
REQ-016 Each gpio_in bit SHALL pass through a two-flop synchronizer, sync1 then sync2, with no logic between the flops.
REQ-017 Each channel SHALL run a per-channel debounce counter cnt of width DB_W with this per-edge rule:
- if sync2 == in_state: cnt <= 0.
- else if cnt >= db_limit: in_state <= sync2 and cnt <= 0.
- else: cnt <= cnt + 1.
REQ-018 The latency from a pin change before edge k to the in_state update SHALL be db_limit+3 edges, i.e. at edge k+2+db_limit.
REQ-019 db_limit = 0 SHALL give an in_state update one edge after sync2 differs.
REQ-020 A sync2 excursion lasting no more than db_limit cycles SHALL leave in_state unchanged and reset cnt.
REQ-021 A change of db_limit mid-count SHALL take effect immediately, using the >= comparison.
REQ-022 cnt SHALL never wrap, because the >= rule bounds it at db_limit.
REQ-023 A 0->1 in_state transition SHALL set rise_flags[i], and a 1->0 transition SHALL set fall_flags[i], on the same edge that in_state updates.
REQ-024 flag_clr[i] SHALL clear rise_flags[i] and fall_flags[i] on the next edge.
REQ-025 When a flag set and its flag_clr occur on the same edge, the set SHALL win and the flag SHALL end at 1.
REQ-026 irq SHALL be registered as the OR over channels of (rise_flags|fall_flags) & irq_mask, one cycle after the flags.
REQ-027 Changing irq_mask SHALL affect irq on the following edge only and SHALL never alter the flags.
REQ-028 Channels SHALL be fully independent.

Reset
REQ-029 While ARESET = 1 at an edge, the block SHALL clear gpio_out, sync1, sync2, in_state, cnt, rise_flags, fall_flags and irq to 0.
REQ-030 A reset asserted mid-debounce SHALL abort the count, and the block SHALL NOT perform any in_state update on that edge.
REQ-031 After reset release, a pin held high SHALL produce in_state = 1 and rise_flags = 1 after db_limit+3 edges; this behaviour is intended.

Configuration
REQ-032 Macro GPIO_EDGE_CAPTURE_EN selects edge capture.
- Defined: edge flags, flag_clr, irq_mask and irq are implemented per REQ-023 to REQ-027.
- Undefined: rise_flags, fall_flags and irq are tied to constant 0; flag_clr and irq_mask are ignored; no flag registers exist.
- Synchronizer, debounce and output path are identical in both builds.

Verification
REQ-033 The bench SHALL cover the following scenarios.
- Output path: out_data_reg=4'b1010 set at edge 10 -> gpio_out=4'b1010 from edge 11; 4'b0000 throughout edges 0-10.
- Debounce: db_limit=5, gpio_in[0] rises before edge 20 and is held -> in_state[0]=1 at edge 27, rise_flags[0]=1 at edge 27, irq=1 at edge 28 (irq_mask=4'b0001).
- Glitch: db_limit=5, gpio_in[1] high for exactly 5 cycles -> in_state[1] stays 0 and fall_flags and rise_flags stay 0.
- Clear collision: flag_clr[2] pulses on the same edge that in_state[2] falls -> fall_flags[2]=1 afterwards; a second flag_clr[2] pulse -> fall_flags[2]=0 next edge and irq=0 one edge later.
- Reset mid-count: db_limit=100, ARESET pulsed for 1 cycle at count 50 with gpio_in[3] held high -> all outputs 0 the edge after, and in_state[3]=1 at 103 edges after reset release.
- Macro off: rerun the debounce scenario without GPIO_EDGE_CAPTURE_EN -> in_state timing identical, rise_flags, fall_flags and irq constantly 0.

Source files
------------

// File: rtl/amdc_gpio_io_conditioner.sv
// GPIO pin conditioning: registered output drive, two-flop input synchronizer,
// per-channel debounce, and optional sticky edge flags with masked interrupt (GPIO_EDGE_CAPTURE_EN).
module amdc_gpio_io_conditioner #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned DB_W = 16
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic [N_CH-1:0] out_data_reg,
    output logic [N_CH-1:0] gpio_out,
    input  logic [N_CH-1:0] gpio_in,
    input  logic [DB_W-1:0] db_limit,
    output logic [N_CH-1:0] in_state,
    output logic [N_CH-1:0] rise_flags,
    output logic [N_CH-1:0] fall_flags,
    input  logic [N_CH-1:0] flag_clr,
    input  logic [N_CH-1:0] irq_mask,
    output logic            irq
);

    logic [N_CH-1:0] r_gpio_out;
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] r_in_state;
    logic [DB_W-1:0] r_cnt [N_CH];
    logic [N_CH-1:0] w_upd;

    // A channel commits its new level once sync2 has disagreed for more than db_limit edges
    always_comb begin
        w_upd = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            w_upd[i] = (r_sync2[i] != r_in_state[i]) && (r_cnt[i] >= db_limit);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_in_state <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_gpio_out <= out_data_reg;
            r_sync1    <= gpio_in;
            r_sync2    <= r_sync1;
            for (int i = 0; i < int'(N_CH); i++) begin
                if (w_upd[i]) begin
                    r_in_state[i] <= r_sync2[i];
                    r_cnt[i]      <= '0;
                end else if (r_sync2[i] == r_in_state[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign gpio_out = r_gpio_out;
    assign in_state = r_in_state;

`ifdef GPIO_EDGE_CAPTURE_EN
    logic [N_CH-1:0] r_rise;
    logic [N_CH-1:0] r_fall;
    logic            r_irq;
    logic [N_CH-1:0] w_set_rise;
    logic [N_CH-1:0] w_set_fall;

    assign w_set_rise = w_upd & r_sync2;
    assign w_set_fall = w_upd & ~r_sync2;

    // Setting an edge flag takes priority over a same-edge clear
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rise <= '0;
            r_fall <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_rise <= w_set_rise | (r_rise & ~flag_clr);
            r_fall <= w_set_fall | (r_fall & ~flag_clr);
            r_irq  <= |((r_rise | r_fall) & irq_mask);
        end
    end

    assign rise_flags = r_rise;
    assign fall_flags = r_fall;
    assign irq        = r_irq;
`else
    logic w_unused_edge;
    assign w_unused_edge = ^{flag_clr, irq_mask};

    assign rise_flags = '0;
    assign fall_flags = '0;
    assign irq        = 1'b0;
`endif

endmodule
